// File: rtl/barrel_fetch.sv
`default_nettype none
// ============================================================================
// barrel_fetch : round-robin multi-thread fetch stage driving the F/D boundary
// Optional feature macro: BARREL_THREAD_MASK_EN (adds thread_en issue mask)
// Rev 1.0
// ============================================================================
module barrel_fetch #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       NUM_THREADS   = 8,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [ADDRESS_WIDTH-1:0] PC_STRIDE     = '0,
  localparam int                      BITS_THREADS  = $clog2(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef BARREL_THREAD_MASK_EN
  input  logic [NUM_THREADS-1:0]   thread_en,
`endif
  input  logic                     stall_f,
  input  logic                     redirect_e,
  input  logic [BITS_THREADS-1:0]  tid_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic [BITS_THREADS-1:0]  tid_f,
  output logic                     valid_f
);

  localparam logic [DATA_WIDTH-1:0] c_nop = DATA_WIDTH'(32'h0000_0013);

  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [BITS_THREADS-1:0]  sel_q, sel_d;
  logic [ADDRESS_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_f_q, pc_plus4_f_d;
  logic [DATA_WIDTH-1:0]    instr_f_q, instr_f_d;
  logic [BITS_THREADS-1:0]  tid_f_q, tid_f_d;
  logic                     valid_f_q, valid_f_d;

  logic [ADDRESS_WIDTH-1:0] w_cur_pc;
  logic [ADDRESS_WIDTH-1:0] w_cur_pc4;
  logic [BITS_THREADS-1:0]  w_next_sel;
  logic                     w_issue;
  logic                     w_squash;

  assign w_cur_pc  = pc_q[sel_q];
  assign w_cur_pc4 = w_cur_pc + ADDRESS_WIDTH'(4);
  assign imem_addr = w_cur_pc;
  assign w_squash  = redirect_e && (tid_e == sel_q);

`ifdef BARREL_THREAD_MASK_EN
  // Descending scan so the nearest enabled successor wins; offset 0 (self) is the last resort.
  always_comb begin
    w_next_sel = sel_q;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      if (thread_en[sel_q + BITS_THREADS'(k)]) begin
        w_next_sel = sel_q + BITS_THREADS'(k);
      end
    end
  end
  assign w_issue = thread_en[sel_q];
`else
  assign w_next_sel = sel_q + BITS_THREADS'(1);
  assign w_issue    = 1'b1;
`endif

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      pc_d[i] = pc_q[i];
    end
    sel_d        = sel_q;
    pc_f_d       = pc_f_q;
    pc_plus4_f_d = pc_plus4_f_q;
    instr_f_d    = instr_f_q;
    tid_f_d      = tid_f_q;
    valid_f_d    = valid_f_q;
    if (!stall_f) begin
      sel_d        = w_next_sel;
      pc_f_d       = w_cur_pc;
      pc_plus4_f_d = w_cur_pc4;
      tid_f_d      = sel_q;
      valid_f_d    = w_issue && !w_squash;
      instr_f_d    = (w_issue && !w_squash) ? imem_rdata : c_nop;
      if (w_issue) begin
        pc_d[sel_q] = w_cur_pc4;
      end
    end
    // Redirect lands last so it overrides the sequential +4 of the same thread.
    if (redirect_e) begin
      pc_d[tid_e] = pc_target_e;
    end
  end

  generate
    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_pc
      localparam logic [ADDRESS_WIDTH-1:0] c_rst_pc = RESET_PC + PC_STRIDE * ADDRESS_WIDTH'(i);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pc_q[i] <= c_rst_pc;
        end else begin
          pc_q[i] <= pc_d[i];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= '0;
      pc_f_q       <= '0;
      pc_plus4_f_q <= '0;
      instr_f_q    <= c_nop;
      tid_f_q      <= '0;
      valid_f_q    <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      pc_f_q       <= pc_f_d;
      pc_plus4_f_q <= pc_plus4_f_d;
      instr_f_q    <= instr_f_d;
      tid_f_q      <= tid_f_d;
      valid_f_q    <= valid_f_d;
    end
  end

  assign pc_f       = pc_f_q;
  assign pc_plus4_f = pc_plus4_f_q;
  assign instr_f    = instr_f_q;
  assign tid_f      = tid_f_q;
  assign valid_f    = valid_f_q;

endmodule
`default_nettype wire
